// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair (rev 1.0).
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
`default_nettype none

module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             rd_req,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               sign_a_q, sign_a_d;
   logic               bz_q, bz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               w_valid;
   logic               w_signed;
   logic               w_isdiv;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_trial;
   logic               w_fits;
   logic [2*WIDTH-1:0] w_add;

   assign w_valid  = start && (funct[5:2] == 4'b0110);
   assign w_signed = ~funct[0];
   assign w_isdiv  = funct[1];
   assign w_a_mag  = (w_signed && op_a[WIDTH-1]) ? -op_a : op_a;
   assign w_b_mag  = (w_signed && op_b[WIDTH-1]) ? -op_b : op_b;

   // Restoring divide: acc holds {remainder, dividend/quotient}; trial-subtract the shifted remainder.
   assign w_trial  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mplr_q};
   assign w_fits   = ~w_trial[WIDTH];
   assign w_add    = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      sign_a_d = sign_a_q;
      bz_d     = bz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (w_valid) begin
               is_div_d = w_isdiv;
               sign_a_d = w_signed & op_a[WIDTH-1];
               neg_d    = w_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
               bz_d     = (op_b == '0);
               mplr_d   = w_b_mag;
               count_d  = CW'(WIDTH);
               if (w_isdiv) begin
                  acc_d   = {{WIDTH{1'b0}}, w_a_mag};
                  mcand_d = '0;
               end else begin
                  acc_d   = '0;
                  mcand_d = {{WIDTH{1'b0}}, w_a_mag};
               end
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            count_d = count_q - CW'(1);
            if (is_div_q) begin
               acc_d = {(w_fits ? w_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]),
                        acc_q[WIDTH-2:0], w_fits};
            end else begin
               acc_d   = w_add;
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
            end
            if (count_q == CW'(1)) state_d = S_FIXUP;
`ifdef MULDIV_EARLY_OUT_EN
            if (!is_div_q && (mplr_q == '0)) state_d = S_FIXUP;
`else
`endif
         end
         S_FIXUP: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (is_div_q) begin
               // A zero divisor yields all-ones quotient naturally, but sign fixup must not touch it.
               lo_d = bz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
               hi_d = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
               dz_d = bz_q;
            end else begin
               {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         sign_a_q <= 1'b0;
         bz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         sign_a_q <= sign_a_d;
         bz_q     <= bz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = (state_q != S_IDLE);
   assign stall    = busy & (start | rd_req | hi_we | lo_we);
   assign done     = done_q;
   assign div_zero = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against an arithmetic reference model.
`default_nettype none

module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  funct = 6'h0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        rd_req = 1'b0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] hi, lo;
   logic        busy, stall, done, div_zero;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
      .op_a(op_a), .op_b(op_b), .rd_req(rd_req), .hi_we(hi_we),
      .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo), .busy(busy),
      .stall(stall), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output logic ez);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ez = 1'b0;
      p  = '0;
      eh = '0;
      el = '0;
      case (f)
         6'h18: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
         6'h19: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
         6'h1a: begin
            if (b == 0) begin eh = a; el = '1; ez = 1'b1; end
            else begin el = 32'(sa / sb); eh = 32'(sa % sb); end
         end
         default: begin
            if (b == 0) begin eh = a; el = '1; ez = 1'b1; end
            else begin el = a / b; eh = a % b; end
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [5:0] f, input logic [31:0] b);
      int lat;
      lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
      if (f == 6'h18 || f == 6'h19) begin
         logic [31:0] m;
         int bl;
         m  = (f == 6'h18 && b[31]) ? -b : b;
         bl = 0;
         for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
         lat = ((bl + 1 < 32) ? bl + 1 : 32) + 1;
      end
`endif
      return lat;
   endfunction

   // Issues one op and follows it to done; optional rd_req hold, mid-op disturbance, MTHI with start.
   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_rd, input bit disturb, input bit mt_with_start);
      logic [31:0] eh, el, prev_hi, prev_lo;
      logic        ez;
      int          n;
      bit          hold_ok, stall_ok, seen;
      model(f, a, b, eh, el, ez);
      @(negedge clk);
      start = 1'b1; funct = f; op_a = a; op_b = b;
      if (mt_with_start) begin hi_we = 1'b1; wdata = 32'h5555_AAAA; end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; rd_req = hold_rd;
      if (mt_with_start) chk("mthi_with_start", hi, 32'h5555_AAAA);
      prev_hi = hi; prev_lo = lo;
      hold_ok = 1; stall_ok = 1; seen = 0; n = 0;
      while (n < 100) begin
         @(posedge clk); #1;
         n++;
         start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         if (done) begin seen = 1; break; end
         if (hi !== prev_hi || lo !== prev_lo || busy !== 1'b1) hold_ok = 0;
         if (hold_rd && stall !== 1'b1) stall_ok = 0;
         if (disturb && n == 5) begin
            start = 1'b1; funct = 6'h19; op_a = 32'd9; op_b = 32'd9;
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            #1 if (stall !== 1'b1) stall_ok = 0;
         end
      end
      chk($sformatf("done_seen f=%h", f), 64'(seen), 64'd1);
      chk($sformatf("latency f=%h a=%h b=%h", f, a, b), 64'(n), 64'(exp_lat(f, b)));
      chk($sformatf("hi f=%h a=%h b=%h", f, a, b), 64'(hi), 64'(eh));
      chk($sformatf("lo f=%h a=%h b=%h", f, a, b), 64'(lo), 64'(el));
      chk("div_zero", 64'(div_zero), 64'(ez));
      chk("hold_during_calc", 64'(hold_ok), 64'd1);
      if (hold_rd || disturb) begin
         chk("stall_while_busy", 64'(stall_ok), 64'd1);
         chk("stall_done_cycle", 64'(stall), 64'd0);
      end
      rd_req = 1'b0;
      @(posedge clk); #1;
      chk("done_pulse", 64'(done), 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #12;
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      // MTHI / MTLO in idle
      @(negedge clk); hi_we = 1'b1; wdata = 32'h1111_2222;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h3333_4444;
      @(negedge clk); lo_we = 1'b0;
      chk("mthi", 64'(hi), 64'h1111_2222);
      chk("mtlo", 64'(lo), 64'h3333_4444);

      // Unrecognised funct must not start anything
      @(negedge clk); start = 1'b1; funct = 6'h20; op_a = 32'd3; op_b = 32'd4;
      @(posedge clk); #1 start = 1'b0;
      chk("bad_funct_busy", 64'(busy), 64'd0);
      chk("bad_funct_hi", 64'(hi), 64'h1111_2222);

      run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
      run_op(6'h18, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
      run_op(6'h1b, 32'd7, 32'd2, 0, 0, 0);
      run_op(6'h1a, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
      run_op(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      run_op(6'h1b, 32'h0000_1234, 32'd0, 0, 0, 0);
      run_op(6'h1a, 32'hFFFF_FF00, 32'd0, 0, 0, 0);
      run_op(6'h1b, 32'd100, 32'd7, 1, 0, 0);
      run_op(6'h1a, 32'd1000, 32'hFFFF_FFFD, 0, 1, 0);
      run_op(6'h19, 32'd6, 32'd7, 0, 0, 1);
      run_op(6'h18, 32'd5, 32'd0, 0, 0, 0);

      // Reset in the middle of an op
      run_op(6'h1b, 32'd7, 32'd2, 0, 0, 0);
      @(negedge clk); start = 1'b1; funct = 6'h1b; op_a = 32'd50; op_b = 32'd3;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midop_rst_hi", 64'(hi), 64'd0);
      chk("midop_rst_lo", 64'(lo), 64'd0);
      chk("midop_rst_busy", 64'(busy), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      run_op(6'h1b, 32'd50, 32'd3, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [5:0] f;
         f = 6'h18 + 6'($urandom_range(0, 3));
         run_op(f, pick(), pick(), bit'($urandom_range(0, 1)), 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
